bcd_lap_timer: RTL and testbench
================================

// Module: bcd_lap_timer
// PURPOSE
//  Parametrised BCD stopwatch/countdown timer, the successor to the fixed 6-digit stopwatch.
//  - Digit count and per-digit modulus are parameters; the tick divisor is a parameter.
//  - Adds up/down mode, preset load, sticky expiry and a lap (split) capture register.
//  - Sits between the board clock and the 7-seg display mux; digits out are registered BCD.
// PARAMETERS
//  DVSR     1_000_000          clk cycles per count tick (0.01 s at 100 MHz); >=2
//  N_DIG    6                  number of BCD digits, d0 = least significant
//  DIG_MAX  24'h59_5999        packed per-digit max value (4 bits/digit, d0 in [3:0]); each nibble 1..9
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset: synchronous, active-high
//  en         in   1          run enable; prescaler and counting advance only while high
//  clr        in   1          synchronous clear of count, prescaler, lap and expired
//  mode       in   1          0 = count up, 1 = count down
//  load       in   1          preset count from load_val
//  load_val   in   4*N_DIG    preset value, packed BCD
//  lap        in   1          capture the current count into lap_q
//  tick       out  1          1-cycle pulse when a count step occurs (combinational from prescaler)
//  digits     out  4*N_DIG    current count, packed BCD
//  lap_q      out  4*N_DIG    last captured count
//  lap_valid  out  1          high once a lap has been captured since the last rst/clr/load
//  wrap       out  1          1-cycle pulse: up-count rolled over from all-max to zero
//  expired    out  1          sticky: down-count reached zero
// BEHAVIOUR
//  - Reset: digits, lap_q, prescaler = 0; lap_valid, wrap, expired = 0.
//  - Priority each cycle: rst > clr > load > tick step. lap is evaluated independently of load and tick.
//  - Prescaler counts 0..DVSR-1 while en=1 and holds while en=0.
//    - tick = en && (psc == DVSR-1); psc wraps to 0 on that cycle.
//    - The period is exactly DVSR cycles.
//  - clr: digits, lap_q, psc = 0; lap_valid = expired = 0.
//  - load: each digit = min(load_val nibble, DIG_MAX nibble); psc = 0; lap_valid = expired = 0.
//  - Up step (mode=0, tick):
//    - Increment d0. A digit at its DIG_MAX goes to 0 and carries into the next digit.
//    - Carry out of the top digit: all digits 0 and wrap=1 in the same cycle the digits update (registered).
//  - Down step (mode=1, tick, expired=0):
//    - Decrement d0. A digit at 0 goes to its DIG_MAX and borrows from the next digit.
//    - When the result is all zeros, set expired=1 in the same update.
//  - Down mode with expired=1, or with digits all zero: ticks are ignored (no underflow) and digits hold.
//  - expired clears only on rst/clr/load.
//  - Mode change takes effect on the next tick. The prescaler is not disturbed.
//  - lap=1: lap_q = digits value before any same-cycle update; lap_valid = 1.
//    - If clr/rst is also high, clr/rst wins.
//    - If load is also high, the capture still occurs and lap_valid = 1.
//  - Latency: one clk from a tick cycle to updated digits. One clk from lap to lap_q.
//  - en=0 does not block clr, load or lap.
//  - Out-of-range digit values cannot arise: load clamps to DIG_MAX.
// STRUCTURE
//  - Package stopwatch_pkg:
//    - BCD_W = 4
//    - typedef logic [3:0] bcd_t
//    - typedef enum logic {CNT_UP, CNT_DOWN} cnt_mode_e
//    - function bcd_clamp(bcd_t v, bcd_t max)
//  - Sub-module bcd_digit (one instance per digit via generate).
//    - Parameter MAX.
//    - Inputs: step, dir, ld, ld_val, clr.
//    - Outputs: q, carry_out (at MAX & up), borrow_out (at 0 & down).
//    - Carry/borrow chain is combinational (d0 -> top).
//  - Top level: prescaler, chain, zero detect, lap register, flags.
// TESTING  (sim with DVSR=4, default N_DIG/DIG_MAX)
//  1. rst, en=1 for 40 cycles
//     -> tick every 4th cycle; digits = 0x000010 after 10 ticks; no wrap.
//  2. load 0x595998, en=1, 2 ticks
//     -> 0x595999, then 0x000000 with wrap high for exactly 1 cycle.
//  3. mode=1, load 0x000100, en=1
//     -> 0x000099 after 1 tick; after 100 ticks 0x000000 with expired=1; further ticks hold 0.
//  4. lap pulsed on the tick cycle at count 0x000041
//     -> lap_q = 0x000041, lap_valid=1; digits continue to 0x000042.
//  5. en toggled 0 mid-prescale for 7 cycles
//     -> psc and digits frozen; resume yields the next tick exactly DVSR-elapsed cycles later.
//  6. rst and clr mid-count, each coincident with tick+lap+load
//     -> all outputs 0 next cycle; load 0x9A9999 clamps to 0x595999.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD lap timer.
package stopwatch_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic {CNT_UP, CNT_DOWN} cnt_mode_e;

    function automatic bcd_t bcd_clamp(bcd_t v, bcd_t max);
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with its own modulus; carry/borrow outputs feed the next digit's step.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic dir,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic clr,
    output bcd_t q,
    output logic carry_out,
    output logic borrow_out
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (ld) begin
            q <= bcd_clamp(ld_val, MAX);
        end else if (step) begin
            if (dir)
                q <= (q == '0) ? MAX : q - BCD_W'(1);
            else
                q <= (q == MAX) ? '0 : q + BCD_W'(1);
        end
    end

    assign carry_out  = !dir && (q == MAX);
    assign borrow_out = dir && (q == '0);

endmodule

// File: rtl/bcd_lap_timer.sv
// Parametrised BCD up/down timer with prescaler, preset load, sticky expiry and lap capture.
module bcd_lap_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned DVSR    = 1_000_000,
    parameter int unsigned N_DIG   = 6,
    parameter logic [4*N_DIG-1:0] DIG_MAX = 24'h59_5999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               mode,
    input  logic               load,
    input  logic [4*N_DIG-1:0] load_val,
    input  logic               lap,
    output logic               tick,
    output logic [4*N_DIG-1:0] digits,
    output logic [4*N_DIG-1:0] lap_q,
    output logic               lap_valid,
    output logic               wrap,
    output logic               expired
);

    localparam int unsigned PSC_W = (DVSR > 2) ? $clog2(DVSR) : 1;
    localparam int unsigned CNT_W = BCD_W * N_DIG;

    logic [PSC_W-1:0] psc;
    logic [N_DIG:0]   step_chain;
    logic [N_DIG-1:0] carry, borrow;
    cnt_mode_e        cnt_mode;
    logic             hold_off;
    logic             all_zero;
    logic             up_step;
    logic             down_step;

    assign cnt_mode  = cnt_mode_e'(mode);
    assign hold_off  = clr || load;
    assign tick      = en && (psc == PSC_W'(DVSR - 1));
    assign all_zero  = (digits == '0);
    assign up_step   = tick && !hold_off && (cnt_mode == CNT_UP);
    assign down_step = tick && !hold_off && (cnt_mode == CNT_DOWN) && !expired && !all_zero;

    // Prescaler: restarts on clr/load, freezes while en is low.
    always_ff @(posedge clk) begin
        if (rst || hold_off)
            psc <= '0;
        else if (tick)
            psc <= '0;
        else if (en)
            psc <= psc + PSC_W'(1);
    end

    assign step_chain[0] = up_step || down_step;

    for (genvar i = 0; i < N_DIG; i++) begin : g_dig
        bcd_digit #(
            .MAX (bcd_t'(DIG_MAX[BCD_W*i +: BCD_W]))
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .step       (step_chain[i]),
            .dir        (cnt_mode == CNT_DOWN),
            .ld         (load),
            .ld_val     (load_val[BCD_W*i +: BCD_W]),
            .clr        (clr),
            .q          (digits[BCD_W*i +: BCD_W]),
            .carry_out  (carry[i]),
            .borrow_out (borrow[i])
        );
        assign step_chain[i+1] = step_chain[i] && (carry[i] || borrow[i]);
    end

    // Flags: wrap is a one-cycle pulse, expired stays set until rst/clr/load.
    always_ff @(posedge clk) begin
        if (rst || hold_off) begin
            wrap    <= 1'b0;
            expired <= 1'b0;
        end else begin
            wrap <= up_step && step_chain[N_DIG];
            if (down_step && (digits == CNT_W'(1)))
                expired <= 1'b1;
        end
    end

    // Lap capture samples the pre-update count; load alone invalidates it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lap_q     <= '0;
            lap_valid <= 1'b0;
        end else if (lap) begin
            lap_q     <= digits;
            lap_valid <= 1'b1;
        end else if (load) begin
            lap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_lap_timer.sv
// Directed bench for bcd_lap_timer with DVSR=4 and the default 6-digit layout.
module tb_bcd_lap_timer;

    logic        clk = 1'b0;
    logic        rst, en, clr, mode, load, lap;
    logic [23:0] load_val;
    logic        tick, lap_valid, wrap, expired;
    logic [23:0] digits, lap_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_lap_timer #(.DVSR(4), .N_DIG(6), .DIG_MAX(24'h59_5999)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .lap       (lap),
        .tick      (tick),
        .digits    (digits),
        .lap_q     (lap_q),
        .lap_valid (lap_valid),
        .wrap      (wrap),
        .expired   (expired)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [23:0] v, input logic m);
        mode = m; load_val = v; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0; load = 1'b0; lap = 1'b0; load_val = '0;
        run(2);
        rst = 1'b0;
        n_tests++;
        if (digits !== 24'h0 || lap_q !== 24'h0 || lap_valid !== 1'b0 || wrap !== 1'b0 || expired !== 1'b0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: digits=%h lap_q=%h lv=%b wrap=%b exp=%b tick=%b, want all 0",
                     digits, lap_q, lap_valid, wrap, expired, tick);
        end
    endtask

    task automatic test_count_up();
        int ticks = 0;
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            n_tests++;
            if (tick !== ((k % 4) == 3) || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL count_up_tick[%0d]: tick=%b wrap=%b, want tick=%b wrap=0", k, tick, wrap, (k % 4) == 3);
            end
            if (tick === 1'b1) ticks++;
            cyc();
        end
        n_tests++;
        if (digits !== 24'h000010 || ticks != 10) begin
            n_fail++;
            $display("FAIL count_up_value: digits=%h ticks=%0d, want 000010 ticks=10", digits, ticks);
        end
    endtask

    task automatic test_wrap();
        do_load(24'h595998, 1'b0);
        run(4);
        n_tests++;
        if (digits !== 24'h595999 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pre: digits=%h wrap=%b, want 595999 wrap=0", digits, wrap);
        end
        run(4);
        n_tests++;
        if (digits !== 24'h000000 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_edge: digits=%h wrap=%b, want 000000 wrap=1", digits, wrap);
        end
        cyc();
        n_tests++;
        if (wrap !== 1'b0 || digits !== 24'h000000) begin
            n_fail++;
            $display("FAIL wrap_pulse: digits=%h wrap=%b, want 000000 wrap=0", digits, wrap);
        end
    endtask

    task automatic test_count_down();
        do_load(24'h000100, 1'b1);
        run(4);
        n_tests++;
        if (digits !== 24'h000099 || expired !== 1'b0) begin
            n_fail++;
            $display("FAIL down_first: digits=%h exp=%b, want 000099 exp=0", digits, expired);
        end
        run(4 * 98);
        n_tests++;
        if (digits !== 24'h000001 || expired !== 1'b0) begin
            n_fail++;
            $display("FAIL down_near: digits=%h exp=%b, want 000001 exp=0", digits, expired);
        end
        run(4);
        n_tests++;
        if (digits !== 24'h000000 || expired !== 1'b1) begin
            n_fail++;
            $display("FAIL down_expire: digits=%h exp=%b, want 000000 exp=1", digits, expired);
        end
        run(12);
        n_tests++;
        if (digits !== 24'h000000 || expired !== 1'b1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL down_hold: digits=%h exp=%b wrap=%b, want 000000 exp=1 wrap=0", digits, expired, wrap);
        end
    endtask

    task automatic test_lap();
        do_load(24'h000040, 1'b0);
        run(4);
        n_tests++;
        if (digits !== 24'h000041 || expired !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_setup: digits=%h exp=%b, want 000041 exp=0", digits, expired);
        end
        run(3);
        lap = 1'b1;
        #1;
        n_tests++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_tick: tick=%b, want 1", tick);
        end
        cyc();
        lap = 1'b0;
        n_tests++;
        if (lap_q !== 24'h000041 || lap_valid !== 1'b1 || digits !== 24'h000042) begin
            n_fail++;
            $display("FAIL lap_capture: lap_q=%h lv=%b digits=%h, want 000041 1 000042", lap_q, lap_valid, digits);
        end
    endtask

    task automatic test_en_freeze();
        run(2);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            n_tests++;
            if (tick !== 1'b0 || digits !== 24'h000042) begin
                n_fail++;
                $display("FAIL freeze[%0d]: tick=%b digits=%h, want 0 000042", k, tick, digits);
            end
            cyc();
        end
        en = 1'b1;
        #1;
        n_tests++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_early: tick=%b, want 0", tick);
        end
        cyc();
        n_tests++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_tick: tick=%b, want 1", tick);
        end
        cyc();
        n_tests++;
        if (digits !== 24'h000043) begin
            n_fail++;
            $display("FAIL resume_value: digits=%h, want 000043", digits);
        end
    endtask

    task automatic test_rst_clr_priority();
        run(3);
        rst = 1'b1; lap = 1'b1; load = 1'b1; load_val = 24'h123456;
        cyc();
        rst = 1'b0; lap = 1'b0; load = 1'b0;
        n_tests++;
        if (digits !== 24'h0 || lap_q !== 24'h0 || lap_valid !== 1'b0 || wrap !== 1'b0 || expired !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_priority: digits=%h lap_q=%h lv=%b wrap=%b exp=%b, want all 0",
                     digits, lap_q, lap_valid, wrap, expired);
        end
        do_load(24'h000001, 1'b1);
        run(2);
        lap = 1'b1;
        cyc();
        lap = 1'b0;
        cyc();
        n_tests++;
        if (digits !== 24'h0 || expired !== 1'b1 || lap_valid !== 1'b1 || lap_q !== 24'h000001) begin
            n_fail++;
            $display("FAIL clr_setup: digits=%h exp=%b lv=%b lap_q=%h, want 000000 1 1 000001",
                     digits, expired, lap_valid, lap_q);
        end
        run(3);
        clr = 1'b1; lap = 1'b1; load = 1'b1; load_val = 24'h000777;
        #1;
        n_tests++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_tick: tick=%b, want 1", tick);
        end
        cyc();
        clr = 1'b0; lap = 1'b0; load = 1'b0;
        n_tests++;
        if (digits !== 24'h0 || lap_q !== 24'h0 || lap_valid !== 1'b0 || wrap !== 1'b0 || expired !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_priority: digits=%h lap_q=%h lv=%b wrap=%b exp=%b, want all 0",
                     digits, lap_q, lap_valid, wrap, expired);
        end
    endtask

    task automatic test_load_clamp();
        en = 1'b0;
        do_load(24'h9A9999, 1'b0);
        n_tests++;
        if (digits !== 24'h595999) begin
            n_fail++;
            $display("FAIL load_clamp: digits=%h, want 595999", digits);
        end
        lap = 1'b1;
        do_load(24'h000007, 1'b0);
        lap = 1'b0;
        n_tests++;
        if (digits !== 24'h000007 || lap_q !== 24'h595999 || lap_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL load_lap: digits=%h lap_q=%h lv=%b, want 000007 595999 1", digits, lap_q, lap_valid);
        end
        do_load(24'h000003, 1'b0);
        n_tests++;
        if (digits !== 24'h000003 || lap_valid !== 1'b0 || lap_q !== 24'h595999) begin
            n_fail++;
            $display("FAIL load_invalidate: digits=%h lv=%b lap_q=%h, want 000003 0 595999", digits, lap_valid, lap_q);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_count_down();
        test_lap();
        test_en_freeze();
        test_rst_clr_priority();
        test_load_clamp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
